// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and command/error output bundle of the UART frame parser.
// master: the parser itself; slave: the byte receiver plus command consumer side.
interface uart_frame_parser_if;
   logic [7:0]  data_byte;
   logic        rx_done;
   logic [7:0]  cmd_code;
   logic [31:0] cmd_addr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        frame_err;
   logic [1:0]  err_code;

   modport master (
      input  data_byte, rx_done, cmd_ready,
      output cmd_code, cmd_addr, cmd_valid, frame_err, err_code
   );

   modport slave (
      output data_byte, rx_done, cmd_ready,
      input  cmd_code, cmd_addr, cmd_valid, frame_err, err_code
   );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles 8-byte frames (HDR0 HDR1 CMD A3 A2 A1 A0 CHK) into ICAPE2 commands.
// Define FRAME_TIMEOUT_EN to abort frames that stall longer than TIMEOUT_CYC between bytes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | hunting for HDR0
// S_HDR  | HDR0 seen, expecting HDR1 (another HDR0 resyncs)
// S_CMD  | expecting the command byte
// S_ADDR | collecting four address bytes, MSB first
// S_CHK  | expecting the checksum byte
// S_OUT  | command presented, waiting for cmd_ready
module uart_frame_parser #(
   parameter logic [7:0]  HDR0        = 8'h55,
   parameter logic [7:0]  HDR1        = 8'hAA,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_frame_parser_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_CMD,
      S_ADDR,
      S_CHK,
      S_OUT
   } state_t;

   localparam logic [1:0] ERR_CHK = 2'b01;
   localparam logic [1:0] ERR_OVR = 2'b11;

   state_t      state;
   logic [7:0]  sum;
   logic [1:0]  idx;
   logic [7:0]  code_sh;
   logic [31:0] addr_sh;

`ifdef FRAME_TIMEOUT_EN
   localparam logic [1:0]  ERR_TO  = 2'b10;
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] to_cnt;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         sum           <= 8'h00;
         idx           <= 2'd0;
         code_sh       <= 8'h00;
         addr_sh       <= 32'h0;
         bus.cmd_code  <= 8'h00;
         bus.cmd_addr  <= 32'h0;
         bus.cmd_valid <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.err_code  <= 2'b00;
`ifdef FRAME_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         bus.frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.rx_done && bus.data_byte == HDR0) state <= S_HDR;
            end
            S_HDR: begin
               if (bus.rx_done) begin
                  if (bus.data_byte == HDR1)      state <= S_CMD;
                  else if (bus.data_byte != HDR0) state <= S_IDLE;
               end
            end
            S_CMD: begin
               if (bus.rx_done) begin
                  code_sh <= bus.data_byte;
                  sum     <= bus.data_byte;
                  idx     <= 2'd0;
                  state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.rx_done) begin
                  addr_sh <= {addr_sh[23:0], bus.data_byte};
                  sum     <= sum + bus.data_byte;
                  idx     <= idx + 2'd1;
                  if (idx == 2'd3) state <= S_CHK;
               end
            end
            S_CHK: begin
               if (bus.rx_done) begin
                  if (bus.data_byte == sum) begin
                     bus.cmd_code  <= code_sh;
                     bus.cmd_addr  <= addr_sh;
                     bus.cmd_valid <= 1'b1;
                     state         <= S_OUT;
                  end else begin
                     bus.frame_err <= 1'b1;
                     bus.err_code  <= ERR_CHK;
                     state         <= S_IDLE;
                  end
               end
            end
            S_OUT: begin
               // acceptance wins over a colliding byte: it is dropped silently
               if (bus.cmd_ready) begin
                  bus.cmd_valid <= 1'b0;
                  state         <= S_IDLE;
               end else if (bus.rx_done) begin
                  bus.frame_err <= 1'b1;
                  bus.err_code  <= ERR_OVR;
               end
            end
            default: state <= S_IDLE;
         endcase

`ifdef FRAME_TIMEOUT_EN
         // a byte arriving in the expiry cycle clears the counter and is processed above
         if (bus.rx_done || state == S_IDLE || state == S_OUT) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            to_cnt        <= '0;
            state         <= S_IDLE;
            bus.frame_err <= 1'b1;
            bus.err_code  <= ERR_TO;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frame vector table plus overrun, reset and timeout sequences.
module tb_uart_frame_parser;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_frame_parser_if bus ();

   uart_frame_parser #(
      .HDR0        (8'h55),
      .HDR1        (8'hAA),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0]  b [10];
      int          n;
      logic        exp_valid;
      logic [7:0]  exp_code;
      logic [31:0] exp_addr;
      int          exp_errs;
      logic [1:0]  exp_ec;
   } vec_t;

   vec_t vecs [6];
   int   checks = 0;
   int   errors = 0;
   int   err_cnt = 0;

   always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      bus.data_byte = d;
      bus.rx_done   = 1'b1;
      @(negedge clk);
      bus.rx_done   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b [10], input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         send_byte(b[i]);
         if (i != n - 1) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic check_outputs(input string tag, input logic v, input logic [7:0] c, input logic [31:0] a);
      chk({tag, " cmd_valid"}, 32'(bus.cmd_valid), 32'(v));
      chk({tag, " cmd_code"},  32'(bus.cmd_code),  32'(c));
      chk({tag, " cmd_addr"},  bus.cmd_addr,       a);
   endtask

   task automatic accept(input string tag);
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      chk({tag, " valid_after_accept"}, 32'(bus.cmd_valid), 32'd0);
   endtask

   logic [7:0] fb [10];
   int         base;
   int         waited;

   initial begin
      bus.data_byte = 8'h00;
      bus.rx_done   = 1'b0;
      bus.cmd_ready = 1'b0;

      vecs[0] = '{b: '{8'h55,8'hAA,8'h01,8'h00,8'h00,8'h10,8'h00,8'h11,8'h00,8'h00}, n: 8,
                  exp_valid: 1'b1, exp_code: 8'h01, exp_addr: 32'h0000_1000, exp_errs: 0, exp_ec: 2'b00};
      vecs[1] = '{b: '{8'h55,8'hAA,8'h02,8'h12,8'h34,8'h56,8'h78,8'h00,8'h00,8'h00}, n: 8,
                  exp_valid: 1'b0, exp_code: 8'h01, exp_addr: 32'h0000_1000, exp_errs: 1, exp_ec: 2'b01};
      vecs[2] = '{b: '{8'h33,8'h55,8'h55,8'hAA,8'h0F,8'h00,8'h00,8'h00,8'h01,8'h10}, n: 10,
                  exp_valid: 1'b1, exp_code: 8'h0F, exp_addr: 32'h0000_0001, exp_errs: 0, exp_ec: 2'b01};
      vecs[3] = '{b: '{8'h55,8'h12,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n: 2,
                  exp_valid: 1'b0, exp_code: 8'h0F, exp_addr: 32'h0000_0001, exp_errs: 0, exp_ec: 2'b01};
      vecs[4] = '{b: '{8'h55,8'h55,8'h77,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n: 3,
                  exp_valid: 1'b0, exp_code: 8'h0F, exp_addr: 32'h0000_0001, exp_errs: 0, exp_ec: 2'b01};
      vecs[5] = '{b: '{8'h55,8'hAA,8'hC3,8'hDE,8'hAD,8'hBE,8'hEF,8'hFB,8'h00,8'h00}, n: 8,
                  exp_valid: 1'b1, exp_code: 8'hC3, exp_addr: 32'hDEAD_BEEF, exp_errs: 0, exp_ec: 2'b01};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_outputs("reset", 1'b0, 8'h00, 32'h0);
      chk("reset frame_err", 32'(bus.frame_err), 32'd0);
      chk("reset err_code",  32'(bus.err_code),  32'd0);

      for (int v = 0; v < 6; v++) begin
         base = err_cnt;
         send_frame(vecs[v].b, vecs[v].n, 1);
         check_outputs($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_code, vecs[v].exp_addr);
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d err_pulses", v), 32'(err_cnt - base), 32'(vecs[v].exp_errs));
         chk($sformatf("vec%0d err_code", v),   32'(bus.err_code),   32'(vecs[v].exp_ec));
         chk($sformatf("vec%0d valid_held", v), 32'(bus.cmd_valid),  32'(vecs[v].exp_valid));
         if (vecs[v].exp_valid) accept($sformatf("vec%0d", v));
      end

      // overrun: command pending, further bytes flagged, colliding byte at acceptance dropped quietly
      base = err_cnt;
      send_frame(vecs[0].b, 8, 1);
      check_outputs("ovr frame", 1'b1, 8'h01, 32'h0000_1000);
      @(negedge clk);
      send_byte(8'h55);
      repeat (2) @(negedge clk);
      chk("ovr err_pulses", 32'(err_cnt - base), 32'd1);
      chk("ovr err_code",   32'(bus.err_code),   32'd3);
      check_outputs("ovr held", 1'b1, 8'h01, 32'h0000_1000);
      bus.cmd_ready = 1'b1;
      send_byte(8'h55);
      bus.cmd_ready = 1'b0;
      chk("ovr collide valid", 32'(bus.cmd_valid), 32'd0);
      repeat (2) @(negedge clk);
      chk("ovr collide err_pulses", 32'(err_cnt - base), 32'd1);

      // back-to-back frames, zero gap, cmd_ready held high throughout
      base = err_cnt;
      bus.cmd_ready = 1'b1;
      fb = '{8'h55,8'hAA,8'h10,8'h00,8'h00,8'h00,8'h20,8'h30,8'h00,8'h00};
      send_frame(fb, 8, 0);
      check_outputs("b2b first", 1'b1, 8'h10, 32'h0000_0020);
      @(negedge clk);
      chk("b2b first accepted", 32'(bus.cmd_valid), 32'd0);
      fb = '{8'h55,8'hAA,8'h02,8'h12,8'h34,8'h56,8'h78,8'h16,8'h00,8'h00};
      send_frame(fb, 8, 0);
      check_outputs("b2b second", 1'b1, 8'h02, 32'h1234_5678);
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      chk("b2b second accepted", 32'(bus.cmd_valid), 32'd0);
      chk("b2b err_pulses", 32'(err_cnt - base), 32'd0);

      // reset after four bytes of a frame; the tail alone must not decode
      fb = '{8'h55,8'hAA,8'h05,8'h12,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      send_frame(fb, 4, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_outputs("midrst", 1'b0, 8'h00, 32'h0);
      chk("midrst err_code", 32'(bus.err_code), 32'd0);
      base = err_cnt;
      fb = '{8'h34,8'h56,8'h78,8'hC3,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      send_frame(fb, 4, 1);
      repeat (2) @(negedge clk);
      check_outputs("midrst tail", 1'b0, 8'h00, 32'h0);
      chk("midrst tail err_pulses", 32'(err_cnt - base), 32'd0);

`ifdef FRAME_TIMEOUT_EN
      fb = '{8'h55,8'hAA,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      send_frame(fb, 3, 1);
      waited = 0;
      while (bus.frame_err !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("timeout cycles", 32'(waited), 32'd100);
      chk("timeout err_code", 32'(bus.err_code), 32'd2);
      @(negedge clk);
      send_frame(vecs[0].b, 8, 1);
      check_outputs("after timeout", 1'b1, 8'h01, 32'h0000_1000);
      accept("after timeout");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
